vga_text_gen: RTL and testbench
===============================

Name: vga_text_gen

Overview:
- Downstream pixel stage of the VGA timing generator: consumes the 640x480 pixel_x/pixel_y counters and hsync/vsync.
- Renders an 80x30 text screen of 8x16 glyphs from a writable character RAM and a font ROM, with a blinking block cursor.
- Delays the sync signals to stay aligned with its rendering pipeline.
- Drives the VGA connector (rgb, hsync, vsync) directly.

Parameters:
- COLS, 80, characters per row.
- ROWS, 30, character rows.
- FG_COLOR, 3'b010, 3-bit RGB for glyph pixels.
- BG_COLOR, 3'b000, 3-bit RGB for background pixels.
- BLINK_BIT, 4, frame-counter bit that gates cursor visibility (period 2^(BLINK_BIT+1) frames).

Ports:
- clk_i  in  1  system clock, same clock as the timing generator (2 clocks per pixel).
- reset_i  in  1  asynchronous, active-low reset.
- pixel_x_i  in  10  current column counter, 0..799.
- pixel_y_i  in  10  current row counter, 0..524.
- hsync_i  in  1  horizontal sync from the timing generator, active-low.
- vsync_i  in  1  vertical sync from the timing generator, active-low.
- wr_en_i  in  1  one-clock write strobe into the character RAM.
- wr_col_i  in  7  write column, 0..COLS-1.
- wr_row_i  in  5  write row, 0..ROWS-1.
- wr_char_i  in  7  ASCII code to store.
- cursor_en_i  in  1  cursor display enable.
- cursor_col_i  in  7  cursor column.
- cursor_row_i  in  5  cursor row.
- hsync_o  out  1  hsync delayed 3 clocks.
- vsync_o  out  1  vsync delayed 3 clocks.
- rgb_o  out  3  pixel colour, registered.
- frame_tick_o  out  1  one-clock pulse at the start of each vertical retrace.

Behaviour:
- Reset (reset_i=0, asynchronous): rgb_o=000, hsync_o=1, vsync_o=1, frame_tick_o=0, frame counter=0, all pipeline registers cleared (syncs cleared to 1). Character RAM is not cleared; its configuration contents are 0x20 in every cell.
- Pipeline is 3 clock stages. rgb_o, hsync_o and vsync_o at edge n+3 correspond to inputs sampled at edge n. The sync delay line is exactly 3 flops so colour and sync stay aligned.
- S1: register pixel_x_i, pixel_y_i, syncs. Compute video_on = (x<640 && y<480), col = x[9:3], row = y[8:4], glyph line = y[3:0], bit = x[2:0]. Issue a synchronous char-RAM read at address row*COLS+col (12 bits, range 0..2399).
- S2: char code available. Issue a synchronous font-ROM read at {code[6:0], line[3:0]} (11 bits, 8-bit data). Carry bit, video_on, syncs and the cursor-hit flag forward.
- S3: pix = font_byte[7-bit] XOR cursor_vis. rgb_o <= video_on ? (pix ? FG_COLOR : BG_COLOR) : 000.
- cursor_vis = cursor_en_i && col==cursor_col_i && row==cursor_row_i && frame_cnt[BLINK_BIT]==0. It is evaluated in S1 and pipelined; the cursor inverts the whole 8x16 cell.
- Blanking (x>=640 or y>=480): rgb_o=000 regardless of RAM contents or cursor.
- Write port: when wr_en_i=1, col<COLS and row<ROWS, store wr_char_i at row*COLS+col on that edge.
  - Out-of-range writes are ignored.
  - A write and a read to the same address in the same cycle return the old data (read-first); the new character is visible from the next read.
- Frame counter: 8-bit, free-running. Increments on a vsync_i 1->0 transition, detected against a registered copy of vsync_i; it wraps 255->0. frame_tick_o is high for exactly the one clock after that detection. A vsync_i already low when reset is released does not produce a tick.
- Cursor row/col inputs may change at any time; the change takes effect on the next sampled pixel with no glitch filtering.
- Reset asserted mid-frame: outputs go to reset values immediately. After release, the rendering output is valid 3 clocks later.

Decomposition:
- Shared package vga_pkg: H_DISPLAY=640, V_DISPLAY=480, GLYPH_W=8, GLYPH_H=16, PIPE_DEPTH=3, colour constants.
- Sub-module font_rom: synchronous 2048x8 ROM, 128 ASCII glyphs of 16 lines, initialised from a memory file.
- The character RAM is inferred inside vga_text_gen as a simple dual-port block RAM.

Test Plan:
- Reset: hold reset_i=0 and toggle the inputs -> rgb_o=000, hsync_o=vsync_o=1, frame_tick_o=0 throughout.
- Latency: drive hsync_i 1->0 at edge n -> hsync_o falls at edge n+3. Write 'A'(0x41) at (0,0) and sweep x=0..7, y=0..15 -> rgb_o reproduces the font bitmap for 0x41 in FG_COLOR/BG_COLOR, 3 clocks after each coordinate.
- Blanking: cell (79,29) holds 0x7F (solid block) and cursor set there; drive x=640..799 or y=480..524 -> rgb_o=000.
- Write boundaries: write col=80 or row=30 -> no RAM cell changes. Write (79,29) with 'Z' in the same cycle as that cell is read -> old glyph this read, 'Z' on the next frame.
- Cursor blink: cursor_en_i=1 at (5,3) on a blank cell, 40 vsync falls -> cell is FG solid during frames with frame_cnt[4]=0 and BG otherwise. frame_tick_o gives exactly 40 single-clock pulses.
- Mid-frame reset: assert reset_i at x=300, y=200, release 10 clocks later -> outputs at reset values during reset, valid rendering resumes 3 clocks after release, frame counter restarts at 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and stage bundles for the VGA text renderer.
// Imported by vga_text_gen and font_rom.
package vga_pkg;

  localparam int H_DISPLAY  = 640;
  localparam int V_DISPLAY  = 480;
  localparam int GLYPH_W    = 8;
  localparam int GLYPH_H    = 16;
  localparam int PIPE_DEPTH = 3;

  localparam logic [2:0] COLOR_BLACK = 3'b000;
  localparam logic [2:0] COLOR_GREEN = 3'b010;

  // Fields carried out of the char-RAM read stage.
  typedef struct packed {
    logic       video;
    logic [2:0] bit_idx;
    logic [3:0] line;
    logic       cursor;
  } s1_t;

  // Fields carried out of the font-ROM read stage.
  typedef struct packed {
    logic       video;
    logic [2:0] bit_idx;
    logic       cursor;
  } s2_t;

  // Linear cell index of a (col,row) position.
  function automatic int cell_addr(
    input logic [6:0] col,
    input logic [4:0] row,
    input int         cols
  );
    return int'(row) * cols + int'(col);
  endfunction

endpackage

// File: rtl/font_rom.sv
// Synchronous 2048x8 glyph ROM, 128 codes x 16 lines.
// Codes without a bitmap in the table render blank.
module font_rom
  import vga_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [10:0] addr_i,
  output logic [7:0]  data_o
);

  // Glyph table; line 0 is the most significant byte.
  function automatic logic [7:0] glyph(
    input logic [6:0] code,
    input logic [3:0] line
  );
    logic [127:0] bmp;
    bmp = '0;
    case (code)
      7'h41: bmp = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
      7'h5A: bmp = 128'h0000_FEC6_860C_1830_60C2_C6FE_0000_0000;
      7'h7F: bmp = '1;
      default: bmp = '0;
    endcase
    return bmp[{~line, 3'b000} +: 8];
  endfunction

  // Registered lookup of the addressed glyph line.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) data_o <= '0;
    else          data_o <= glyph(addr_i[10:4], addr_i[3:0]);
  end

endmodule

// File: rtl/vga_text_gen.sv
// 80x30 text renderer: char RAM -> font ROM -> colour, 3 clocks deep.
// Sync outputs ride a matching 3-flop delay line.
module vga_text_gen
  import vga_pkg::*;
#(
  parameter int         COLS      = 80,
  parameter int         ROWS      = 30,
  parameter logic [2:0] FG_COLOR  = COLOR_GREEN,
  parameter logic [2:0] BG_COLOR  = COLOR_BLACK,
  parameter int         BLINK_BIT = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [9:0] pixel_x_i,
  input  logic [9:0] pixel_y_i,
  input  logic       hsync_i,
  input  logic       vsync_i,
  input  logic       wr_en_i,
  input  logic [6:0] wr_col_i,
  input  logic [4:0] wr_row_i,
  input  logic [6:0] wr_char_i,
  input  logic       cursor_en_i,
  input  logic [6:0] cursor_col_i,
  input  logic [4:0] cursor_row_i,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic [2:0] rgb_o,
  output logic       frame_tick_o
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);
  localparam int XB    = $clog2(GLYPH_W);
  localparam int YB    = $clog2(GLYPH_H);

  logic [6:0]            col;
  logic [4:0]            row;
  logic                  video;
  logic                  cursor_hit;
  logic                  wr_ok;
  logic [AW-1:0]         rd_addr;
  logic [AW-1:0]         wr_addr;
  logic [6:0]            char_code;
  logic [7:0]            font_data;
  logic                  pix;
  logic [7:0]            frame_cnt;
  logic                  armed;
  logic                  vs_fall;
  logic [PIPE_DEPTH-1:0] hs_pipe;
  logic [PIPE_DEPTH-1:0] vs_pipe;
  s1_t                   s1;
  s2_t                   s2;

  logic [6:0] char_mem [CELLS] = '{default: 7'h20};

  assign col   = pixel_x_i[9:XB];
  assign row   = pixel_y_i[YB+4:YB];
  assign video = (32'(pixel_x_i) < H_DISPLAY)
              && (32'(pixel_y_i) < V_DISPLAY);

  assign cursor_hit = cursor_en_i
                   && (col == cursor_col_i)
                   && (row == cursor_row_i)
                   && !frame_cnt[BLINK_BIT];

  assign rd_addr = video ? AW'(cell_addr(col, row, COLS)) : '0;

  assign wr_ok = wr_en_i
              && (32'(wr_col_i) < COLS)
              && (32'(wr_row_i) < ROWS);

  assign wr_addr = AW'(cell_addr(wr_col_i, wr_row_i, COLS));

  // Char RAM: read-first simple dual port, contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_ok) char_mem[wr_addr] <= wr_char_i;
    char_code <= char_mem[rd_addr];
  end

  // Stage 1: latch pixel geometry and cursor hit beside the RAM read.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) s1 <= '0;
    else s1 <= '{
      video:   video,
      bit_idx: pixel_x_i[2:0],
      line:    pixel_y_i[3:0],
      cursor:  cursor_hit
    };
  end

  font_rom u_font (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .addr_i  ({char_code, s1.line}),
    .data_o  (font_data)
  );

  // Stage 2: carry geometry alongside the font read.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) s2 <= '0;
    else s2 <= '{
      video:   s1.video,
      bit_idx: s1.bit_idx,
      cursor:  s1.cursor
    };
  end

  assign pix = font_data[3'd7 - s2.bit_idx] ^ s2.cursor;

  // Stage 3: colour out, black outside the visible area.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)      rgb_o <= '0;
    else if (s2.video) rgb_o <= pix ? FG_COLOR : BG_COLOR;
    else               rgb_o <= '0;
  end

  // Sync delay lines matching the colour pipeline depth.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      hs_pipe <= '1;
      vs_pipe <= '1;
    end else begin
      hs_pipe <= {hs_pipe[PIPE_DEPTH-2:0], hsync_i};
      vs_pipe <= {vs_pipe[PIPE_DEPTH-2:0], vsync_i};
    end
  end

  assign hsync_o = hs_pipe[PIPE_DEPTH-1];
  assign vsync_o = vs_pipe[PIPE_DEPTH-1];

  // vs_pipe[0] only reflects vsync_i after one live sample.
  assign vs_fall = armed && vs_pipe[0] && !vsync_i;

  // Frame counter and retrace tick on each vsync falling edge.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      armed        <= 1'b0;
      frame_cnt    <= '0;
      frame_tick_o <= 1'b0;
    end else begin
      armed        <= 1'b1;
      frame_tick_o <= vs_fall;
      if (vs_fall) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_text_gen.sv
// Directed bench for vga_text_gen.
// Expected pixels come from hand-entered glyph lines.
module tb_vga_text_gen;

  localparam logic [2:0] FG = 3'b010;
  localparam logic [2:0] BG = 3'b000;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [9:0] pixel_x_i, pixel_y_i;
  logic       hsync_i, vsync_i;
  logic       wr_en_i;
  logic [6:0] wr_col_i, wr_char_i;
  logic [4:0] wr_row_i;
  logic       cursor_en_i;
  logic [6:0] cursor_col_i;
  logic [4:0] cursor_row_i;
  logic       hsync_o, vsync_o, frame_tick_o;
  logic [2:0] rgb_o;

  int n_cmp = 0;
  int n_bad = 0;
  int tick_hi = 0;
  int tick_rise = 0;
  logic tick_prev = 1'b0;
  int hi0, rise0;

  logic [7:0] font_a [16] = '{
    8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
    8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00
  };

  always #5 clk = ~clk;

  vga_text_gen dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .pixel_x_i    (pixel_x_i),
    .pixel_y_i    (pixel_y_i),
    .hsync_i      (hsync_i),
    .vsync_i      (vsync_i),
    .wr_en_i      (wr_en_i),
    .wr_col_i     (wr_col_i),
    .wr_row_i     (wr_row_i),
    .wr_char_i    (wr_char_i),
    .cursor_en_i  (cursor_en_i),
    .cursor_col_i (cursor_col_i),
    .cursor_row_i (cursor_row_i),
    .hsync_o      (hsync_o),
    .vsync_o      (vsync_o),
    .rgb_o        (rgb_o),
    .frame_tick_o (frame_tick_o)
  );

  always @(negedge clk) begin
    if (frame_tick_o) tick_hi++;
    if (frame_tick_o && !tick_prev) tick_rise++;
    tick_prev = frame_tick_o;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y);
    pixel_x_i = 10'(x);
    pixel_y_i = 10'(y);
    repeat (3) tick();
  endtask

  task automatic wr(input int c, input int r, input logic [6:0] ch);
    wr_col_i  = 7'(c);
    wr_row_i  = 5'(r);
    wr_char_i = ch;
    wr_en_i   = 1'b1;
    tick();
    wr_en_i   = 1'b0;
  endtask

  task automatic vfall();
    vsync_i = 1'b0;
    repeat (2) tick();
    vsync_i = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    logic [7:0] b;
    reset_i = 1'b0;
    pixel_x_i = '0; pixel_y_i = '0;
    hsync_i = 1'b1; vsync_i = 1'b1;
    wr_en_i = 1'b0; wr_col_i = '0; wr_row_i = '0; wr_char_i = '0;
    cursor_en_i = 1'b1; cursor_col_i = '0; cursor_row_i = '0;

    for (int i = 0; i < 8; i++) begin
      pixel_x_i = 10'(i * 37);
      pixel_y_i = 10'(i * 11);
      hsync_i = i[0];
      vsync_i = i[1];
      tick();
      check("reset_hold", {rgb_o, hsync_o, vsync_o, frame_tick_o},
            6'b000110);
    end
    hsync_i = 1'b1; vsync_i = 1'b1; cursor_en_i = 1'b0;
    tick();
    reset_i = 1'b1;

    pix(300, 200);
    tick();
    hsync_i = 1'b0;
    tick();
    check("hs_lat_n1", hsync_o, 1);
    tick();
    check("hs_lat_n2", hsync_o, 1);
    tick();
    check("hs_lat_n3", hsync_o, 0);
    hsync_i = 1'b1;
    repeat (3) tick();

    wr(0, 0, 7'h41);
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 8; x++) begin
        pix(x, y);
        b = font_a[y];
        check($sformatf("glyphA_%0d_%0d", x, y), rgb_o,
              b[7-x] ? FG : BG);
      end
    end

    wr(79, 29, 7'h7F);
    cursor_col_i = 7'd79; cursor_row_i = 5'd29;
    pix(632, 464);
    check("solid_cell", rgb_o, FG);
    cursor_en_i = 1'b1;
    pix(632, 464);
    check("cursor_invert", rgb_o, BG);
    cursor_col_i = 7'd80; cursor_row_i = 5'd0;
    pix(640, 0);
    check("blank_x640", rgb_o, 0);
    cursor_col_i = 7'd79; cursor_row_i = 5'd29;
    pix(799, 464);
    check("blank_x799", rgb_o, 0);
    pix(632, 480);
    check("blank_y480", rgb_o, 0);
    pix(0, 517);
    check("blank_y517", rgb_o, 0);
    pix(639, 524);
    check("blank_y524", rgb_o, 0);
    cursor_en_i = 1'b0;

    wr(80, 0, 7'h41);
    wr(127, 1, 7'h41);
    wr(0, 30, 7'h41);
    pix(0, 21);
    check("wr_col80", rgb_o, BG);
    pix(376, 37);
    check("wr_col127", rgb_o, BG);
    pix(0, 5);
    check("cell00_kept", rgb_o, FG);

    pixel_x_i = 10'd639; pixel_y_i = 10'd466;
    wr_col_i = 7'd79; wr_row_i = 5'd29; wr_char_i = 7'h5A;
    wr_en_i = 1'b1;
    tick();
    wr_en_i = 1'b0;
    tick();
    tick();
    check("rmw_old", rgb_o, FG);
    tick();
    check("rmw_new", rgb_o, BG);

    cursor_en_i = 1'b1;
    cursor_col_i = 7'd5; cursor_row_i = 5'd3;
    pixel_x_i = 10'd42; pixel_y_i = 10'd55;
    hi0 = tick_hi; rise0 = tick_rise;
    for (int i = 0; i < 40; i++) begin
      repeat (3) tick();
      check($sformatf("blink_f%0d", i), rgb_o, i[4] ? BG : FG);
      vfall();
    end
    tick();
    check("tick_pulses", tick_rise - rise0, 40);
    check("tick_cycles", tick_hi - hi0, 40);

    repeat (8) vfall();
    cursor_col_i = 7'd0; cursor_row_i = 5'd0;
    pix(3, 5);
    check("pre_rst_f48", rgb_o, BG);
    hsync_i = 1'b0;
    repeat (3) tick();
    check("pre_rst_hs", hsync_o, 0);
    #2;
    reset_i = 1'b0;
    #1;
    check("rst_async", {rgb_o, hsync_o, vsync_o, frame_tick_o},
          6'b000110);
    vsync_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_mid", {rgb_o, hsync_o, vsync_o, frame_tick_o},
            6'b000110);
    end
    hi0 = tick_hi;
    #2;
    reset_i = 1'b1;
    @(posedge clk); #1;
    check("rel_e1", rgb_o, 0);
    @(posedge clk); #1;
    check("rel_e2", rgb_o, 0);
    @(posedge clk); #1;
    check("rel_e3_rgb", rgb_o, FG);
    check("rel_e3_hs", hsync_o, 0);
    repeat (4) tick();
    check("no_tick_rel", tick_hi - hi0, 0);
    vsync_i = 1'b1;
    hsync_i = 1'b1;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
